// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: two-flop synchroniser, counter debouncer, edge-qualified
// one-cycle pulse, retriggerable pulse stretcher and saturating event counter per channel.
module input_conditioner #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned STRETCH   = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in,
    input  logic [1:0]                edge_mode,
    input  logic [CHANNELS-1:0]       evt_clr,
    output logic [CHANNELS-1:0]       level_out,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS-1:0]       stretch_out,
    output logic [CHANNELS*CNT_W-1:0] evt_count
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(STRETCH + 1);

    localparam logic [DB_W-1:0]  DbLast  = DB_W'(DB_CYCLES - 1);
    localparam logic [ST_W-1:0]  StLoad  = ST_W'(STRETCH);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {
        EdgeRise = 2'b00,
        EdgeFall = 2'b01,
        EdgeBoth = 2'b10,
        EdgeNone = 2'b11
    } edge_mode_e;

    logic [CHANNELS-1:0]            sync1_q, sync2_q;
    logic [CHANNELS-1:0]            level_q, level_d;
    logic [CHANNELS-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [CHANNELS-1:0]            pulse_q, pulse_d;
    logic [CHANNELS-1:0][ST_W-1:0]  st_cnt_q, st_cnt_d;
    logic [CHANNELS-1:0][CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    logic [CHANNELS-1:0] flip;
    logic [CHANNELS-1:0] rise_edge, fall_edge, qual;
    edge_mode_e          mode;

    assign mode = edge_mode_e'(edge_mode);

    // A flip happens on the edge where the debounce run reaches DB_CYCLES samples;
    // the new level equals the synchronised sample, which gives the edge direction.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            flip[i] = (sync2_q[i] != level_q[i]) && (db_cnt_q[i] == DbLast);
        end
        rise_edge = flip & sync2_q;
        fall_edge = flip & ~sync2_q;
        case (mode)
            EdgeRise: qual = rise_edge;
            EdgeFall: qual = fall_edge;
            EdgeBoth: qual = flip;
            default:  qual = '0;
        endcase
    end

    always_comb begin
        level_d   = level_q;
        db_cnt_d  = db_cnt_q;
        pulse_d   = qual;
        st_cnt_d  = st_cnt_q;
        evt_cnt_d = evt_cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (flip[i]) begin
                level_d[i]  = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end

            if (qual[i]) begin
                st_cnt_d[i] = StLoad;
            end else if (st_cnt_q[i] != '0) begin
                st_cnt_d[i] = st_cnt_q[i] - ST_W'(1);
            end

            // Clear wins over a coincident event; that event is dropped.
            if (evt_clr[i]) begin
                evt_cnt_d[i] = '0;
            end else if (qual[i] && (evt_cnt_q[i] != CntMax)) begin
                evt_cnt_d[i] = evt_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            db_cnt_q  <= '0;
            pulse_q   <= '0;
            st_cnt_q  <= '0;
            evt_cnt_q <= '0;
        end else begin
            sync1_q   <= in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            pulse_q   <= pulse_d;
            st_cnt_q  <= st_cnt_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    always_comb begin
        level_out = level_q;
        pulse_out = pulse_q;
        for (int i = 0; i < CHANNELS; i++) begin
            stretch_out[i]                  = (st_cnt_q[i] != '0);
            evt_count[i*CNT_W +: CNT_W]     = evt_cnt_q[i];
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised scoreboard bench for input_conditioner against a sample-window reference model.
module tb_input_conditioner;

    localparam int CH = 4;
    localparam int DB = 3;
    localparam int ST = 5;
    localparam int CW = 2;
    localparam int NEVER = 1000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   in_r = '0;
    logic [1:0]      edge_mode = 2'b00;
    logic [CH-1:0]   evt_clr = '0;
    logic [CH-1:0]   level_out, pulse_out, stretch_out;
    logic [CH*CW-1:0] evt_count;

    input_conditioner #(
        .CHANNELS (CH),
        .DB_CYCLES(DB),
        .STRETCH  (ST),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_r),
        .edge_mode  (edge_mode),
        .evt_clr    (evt_clr),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .stretch_out(stretch_out),
        .evt_count  (evt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]    level;
        logic [CH-1:0]    pulse;
        logic [CH-1:0]    stretch;
        logic [CH*CW-1:0] count;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: raw input delayed two samples, level flips once the last DB
    // samples since the previous flip all disagree with it.
    bit m_s1[CH];
    bit m_s2[CH];
    bit m_level[CH];
    bit hist[CH][$];
    int since[CH];
    int cnt[CH];

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0;
            hist[i].delete();
            since[i] = NEVER;
            cnt[i] = 0;
        end
    endfunction

    function automatic exp_t model_step(logic [CH-1:0] din, logic [1:0] mode, logic [CH-1:0] clr);
        exp_t e;
        for (int i = 0; i < CH; i++) begin
            bit flip, rising, qual;
            hist[i].push_back(m_s2[i]);
            if (hist[i].size() > DB) void'(hist[i].pop_front());
            flip = (hist[i].size() == DB);
            for (int j = 0; j < hist[i].size(); j++)
                if (hist[i][j] == m_level[i]) flip = 0;
            qual = 0;
            if (flip) begin
                rising = (m_level[i] == 0);
                m_level[i] = !m_level[i];
                hist[i].delete();
                qual = (mode == 2) || (mode == 0 && rising) || (mode == 1 && !rising);
            end
            if (qual) since[i] = 0;
            else if (since[i] < NEVER) since[i]++;
            if (clr[i]) cnt[i] = 0;
            else if (qual && cnt[i] < (1 << CW) - 1) cnt[i]++;
            m_s2[i] = m_s1[i];
            m_s1[i] = din[i];
            e.level[i]   = m_level[i];
            e.pulse[i]   = qual;
            e.stretch[i] = (since[i] < ST);
            e.count[i*CW +: CW] = CW'(cnt[i]);
        end
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.level = '0; e.pulse = '0; e.stretch = '0; e.count = '0;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: one output set per clock, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("level_out", 64'(level_out), 64'(e.level));
                check("pulse_out", 64'(pulse_out), 64'(e.pulse));
                check("stretch_out", 64'(stretch_out), 64'(e.stretch));
                check("evt_count", 64'(evt_count), 64'(e.count));
            end
        end
    end

    logic [CH-1:0] cur = '0;
    int            tp[CH];

    task automatic drive_cycle(bit hold);
        @(negedge clk);
        cyc++;
        if (!hold) begin
            for (int i = 0; i < CH; i++) begin
                if (cyc % 40 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       tp[i] = 2;
                        1:       tp[i] = 6;
                        default: tp[i] = 20;
                    endcase
                end
                if ($urandom_range(0, tp[i] - 1) == 0) cur[i] = ~cur[i];
                evt_clr[i] = ($urandom_range(0, 24) == 0);
            end
            if ($urandom_range(0, 29) == 0) edge_mode = 2'($urandom_range(0, 3));
        end else begin
            evt_clr = '0;
        end
        in_r = cur;
        q.push_back(model_step(in_r, edge_mode, evt_clr));
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_level", 64'(level_out), 64'd0);
        check("rst_pulse", 64'(pulse_out), 64'd0);
        check("rst_stretch", 64'(stretch_out), 64'd0);
        check("rst_count", 64'(evt_count), 64'd0);
        model_reset();
        cur = '1;
        in_r = cur;
        evt_clr = '0;
        edge_mode = 2'b00;
        repeat (2) begin
            @(negedge clk);
            cyc++;
            q.push_back(zero_exp());
        end
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        q.push_back(model_step(in_r, edge_mode, evt_clr));
        repeat (DB + ST + 4) drive_cycle(1'b1);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) tp[i] = 6;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            q.push_back(zero_exp());
        end
        @(negedge clk);
        rst = 1'b1;
        q.push_back(model_step(in_r, edge_mode, evt_clr));
        for (int n = 0; n < 3000; n++) begin
            if (n == 1000 || n == 2000) async_reset();
            drive_cycle(1'b0);
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
